// File: rtl/muldiv_seq_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 op codes,
// FSM state encoding and operand-signedness helpers.
package muldiv_seq_unit_pkg;

   localparam logic [2:0] MDU_MUL    = 3'b000;
   localparam logic [2:0] MDU_MULH   = 3'b001;
   localparam logic [2:0] MDU_MULHSU = 3'b010;
   localparam logic [2:0] MDU_MULHU  = 3'b011;
   localparam logic [2:0] MDU_DIV    = 3'b100;
   localparam logic [2:0] MDU_DIVU   = 3'b101;
   localparam logic [2:0] MDU_REM    = 3'b110;
   localparam logic [2:0] MDU_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MDU_S_IDLE = 2'd0,
      MDU_S_MUL  = 2'd1,
      MDU_S_DIV  = 2'd2,
      MDU_S_DONE = 2'd3
   } mdu_state_e;

   // MUL is treated as signed x signed; its low half is sign-agnostic anyway.
   function automatic logic rs1_signed(input logic [2:0] op);
      return op[2] ? ~op[0] : (op != MDU_MULHU);
   endfunction

   function automatic logic rs2_signed(input logic [2:0] op);
      return op[2] ? ~op[0] : ~op[1];
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, try to subtract
// the divisor, keep the difference when it does not go negative.
module mdu_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic            dividend_bit_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] rem_o,
   output logic            qbit_o
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   assign shifted = {rem_i, dividend_bit_i};
   assign diff    = shifted - {1'b0, divisor_i};
   assign qbit_o  = ~diff[XLEN];
   assign rem_o   = qbit_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready result handoff.
// Define MDU_FAST_MUL_EN to replace the shift-add multiply with a one-shot product.
module muldiv_seq_unit
   import muldiv_seq_unit_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);

   // Handshake: a request moves on valid_i & ready_o (IDLE only, no flush_i);
   // a result moves on valid_o & ready_i, and flush_i overrides either side.
   mdu_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     opnd_q, opnd_d;
   logic [2:0]          op_q, op_d;
   logic                neg_q, neg_d;
   logic                sa_q, sa_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                a_neg, b_neg, div_by_zero, div_ovf;
   logic [XLEN-1:0]     a_mag, b_mag;
   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_next, mul_fix, div_next;
   logic [XLEN-1:0]     div_rem, quo_fix, rem_fix;
   logic                div_qbit;

   assign a_neg       = rs1_signed(op_i) & rs1_i[XLEN-1];
   assign b_neg       = rs2_signed(op_i) & rs2_i[XLEN-1];
   assign a_mag       = a_neg ? -rs1_i : rs1_i;
   assign b_mag       = b_neg ? -rs2_i : rs2_i;
   assign div_by_zero = (rs2_i == '0);
   assign div_ovf     = ~op_i[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);

   // Multiply: acc holds {partial product, remaining multiplier bits}.
   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
   assign mul_fix  = neg_q ? -mul_next : mul_next;

   // Divide: acc holds {partial remainder, dividend bits still to shift in}.
   mdu_div_step #(.XLEN(XLEN)) u_div_step (
      .rem_i          (acc_q[2*XLEN-1:XLEN]),
      .dividend_bit_i (acc_q[XLEN-1]),
      .divisor_i      (opnd_q),
      .rem_o          (div_rem),
      .qbit_o         (div_qbit)
   );
   assign div_next = {div_rem, acc_q[XLEN-2:0], div_qbit};
   assign quo_fix  = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
   assign rem_fix  = sa_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];

`ifdef MDU_FAST_MUL_EN
   logic signed [2*XLEN+1:0] fast_a, fast_b, fast_prod;
   assign fast_a    = {{(XLEN+2){a_neg}}, rs1_i};
   assign fast_b    = {{(XLEN+2){b_neg}}, rs2_i};
   assign fast_prod = fast_a * fast_b;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      op_d     = op_q;
      neg_d    = neg_q;
      sa_d     = sa_q;
      result_d = result_q;
      case (state_q)
         MDU_S_IDLE: begin
            if (valid_i && !flush_i) begin
               op_d  = op_i;
               cnt_d = CNT_W'(XLEN - 1);
               sa_d  = a_neg;
               neg_d = a_neg ^ b_neg;
               if (!op_i[2]) begin
`ifdef MDU_FAST_MUL_EN
                  result_d = (op_i == MDU_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
                  state_d  = MDU_S_DONE;
`else
                  opnd_d  = a_mag;
                  acc_d   = {{XLEN{1'b0}}, b_mag};
                  state_d = MDU_S_MUL;
`endif
               end else if (div_by_zero) begin
                  result_d = op_i[1] ? rs1_i : '1;
                  state_d  = MDU_S_DONE;
               end else if (div_ovf) begin
                  result_d = op_i[1] ? '0 : rs1_i;
                  state_d  = MDU_S_DONE;
               end else begin
                  opnd_d  = b_mag;
                  acc_d   = {{XLEN{1'b0}}, a_mag};
                  state_d = MDU_S_DIV;
               end
            end
         end
         MDU_S_MUL: begin
            if (flush_i) begin
               state_d = MDU_S_IDLE;
            end else begin
               acc_d = mul_next;
               if (cnt_q == '0) begin
                  result_d = (op_q == MDU_MUL) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
                  state_d  = MDU_S_DONE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         MDU_S_DIV: begin
            if (flush_i) begin
               state_d = MDU_S_IDLE;
            end else begin
               acc_d = div_next;
               if (cnt_q == '0) begin
                  result_d = op_q[1] ? rem_fix : quo_fix;
                  state_d  = MDU_S_DONE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         MDU_S_DONE: begin
            if (flush_i || ready_i) state_d = MDU_S_IDLE;
         end
         default: state_d = MDU_S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= MDU_S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         sa_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         sa_q     <= sa_d;
         result_q <= result_d;
      end
   end

   assign ready_o  = (state_q == MDU_S_IDLE);
   assign valid_o  = (state_q == MDU_S_DONE);
   assign busy_o   = (state_q != MDU_S_IDLE);
   assign result_o = result_q;

endmodule

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
- Iterative RV32M/RV64M multiply/divide execute unit. It sits beside the single-cycle ALU in the EX stage.
- It accepts M-type ops decoded by the ALU control path (funct3 encoding), computes over multiple cycles, and returns the result through a valid/ready handshake.
- The EX stage stalls on ready_o/valid_o. Data width is parametrised.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
- clk_i  input  1  system clock
- rst_n_i  input  1  asynchronous active-low reset
- valid_i  input  1  request valid
- ready_o  output  1  unit can accept a request
- op_i  input  3  M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_i  input  XLEN  operand A (dividend / multiplicand)
- rs2_i  input  XLEN  operand B (divisor / multiplier)
- flush_i  input  1  pipeline kill; aborts the in-flight op
- valid_o  output  1  result valid
- ready_i  input  1  consumer accepts result
- result_o  output  XLEN  result
- busy_o  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n_i low):
  - State goes to IDLE. ready_o=1, valid_o=0, busy_o=0, result_o=0.
  - All internal registers are cleared.
- States and transitions:
  - IDLE: waits for a request.
  - MUL: shift-add multiply iterations.
  - DIV: restoring-division iterations.
  - DONE: result held for handoff.
- Acceptance: a request is taken when valid_i & ready_o. ready_o=1 only in IDLE. Operands and op are registered in the acceptance cycle (cycle 0).
- Signed handling:
  - Operands are converted to magnitudes at acceptance, with sign flags kept.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - The sign is corrected in the final iteration cycle.
- MUL path:
  - XLEN iterations build a 2*XLEN product.
  - MUL returns product[XLEN-1:0]. MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
  - valid_o rises in cycle XLEN+1.
- DIV path:
  - Restoring division, one quotient bit per cycle, XLEN iterations.
  - valid_o rises in cycle XLEN+1.
- Special cases (no iteration; DONE entered in cycle 1, valid_o in cycle 1):
  - Divide by zero (rs2==0): DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow (DIV/REM with rs1=-2^(XLEN-1), rs2=-1): DIV gives rs1; REM gives 0.
- Counter: counts down from XLEN-1 to 0. The transition MUL/DIV -> DONE happens when the counter reaches 0. No wrap.
- Output handshake:
  - In DONE, valid_o=1 and result_o is stable until ready_i.
  - On valid_o & ready_i the unit returns to IDLE next cycle. ready_o is 1 in that next cycle, never in the same cycle (no back-to-back accept within the handoff cycle).
- flush_i:
  - Takes effect in any state.
  - Next state is IDLE; valid_o is forced 0 in the following cycle; the result is discarded.
  - flush_i together with valid_i in IDLE: the request is not accepted.
  - flush_i has priority over ready_i in DONE.
- Reset mid-operation: immediate abort; no valid_o is produced.
- Result register: result_o is updated only on the DONE entry and otherwise holds its last value.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- When defined:
  - MUL-class ops use a single-cycle combinational 2*XLEN signed/unsigned product computed from the registered operands.
  - DONE is entered in cycle 1 and valid_o is high in cycle 1. The MUL state is unreachable.
- When undefined: the iterative XLEN-cycle multiply described above is used.
- The DIV path is identical in both builds.

Decomposition:
- Shared package/define file (alongside the existing cpu defines):
  - MDU op codes: MDU_MUL..MDU_REMU, matching funct3.
  - State encodings: MDU_IDLE, MDU_MUL, MDU_DIV, MDU_DONE.
- Sub-module: mdu_div_step.
  - Combinational single restoring step: partial remainder, divisor, next quotient bit.
  - Instantiated once and iterated by the FSM.
- The multiply step stays inline.

Test Plan:
- XLEN=32, MUL rs1=7, rs2=-3 -> result 0xFFFFFFEB. valid_o at cycle 33 (cycle 1 with MDU_FAST_MUL_EN).
- MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU rs1=-1, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -20/3 -> 0xFFFFFFFA. REM -20/3 -> 0xFFFFFFFE. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each gives valid_o at cycle 33.
- Special cases at cycle 1:
  - DIV x/0 with x=5 -> 0xFFFFFFFF. REMU 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000. REM of the same -> 0.
- Flush and reset:
  - DIV issued, flush_i at cycle 10 -> no valid_o ever; ready_o=1 at cycle 11; a new MUL accepted at cycle 11 completes correctly.
  - rst_n_i low mid-op -> outputs go to reset values immediately.
- Hold: result ready with ready_i=0 for 5 cycles -> valid_o and result_o stable and ready_o=0 throughout. ready_i=1 -> ready_o=1 in the next cycle.
